// File: rtl/adam_periph_syscfg_multi.sv
// APB system-configuration block: per-target run/pause/stop/reset control,
// boot address and interrupt-enable registers, plus a broadcast command register.
module adam_periph_syscfg_multi #(
  parameter int unsigned           NO_TGTS       = 4,
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           ADDR_WIDTH    = 32,
  parameter logic [NO_TGTS-1:0]    EN_BOOTSTRAP  = '0,
  parameter logic [ADDR_WIDTH-1:0] RST_BOOT_ADDR = '0,
  parameter int unsigned           TIMEOUT       = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         paddr,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [DATA_WIDTH-1:0]         pwdata,
  input  logic [DATA_WIDTH/8-1:0]       pstrb,
  output logic                          pready,
  output logic [DATA_WIDTH-1:0]         prdata,
  output logic                          pslverr,
  input  logic [NO_TGTS*DATA_WIDTH-1:0] irq_vec,
  output logic [NO_TGTS-1:0]            tgt_rst,
  output logic [NO_TGTS-1:0]            tgt_pause_req,
  input  logic [NO_TGTS-1:0]            tgt_pause_ack,
  output logic [NO_TGTS*ADDR_WIDTH-1:0] tgt_boot_addr,
  output logic [NO_TGTS-1:0]            tgt_irq
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned ALIGN  = $clog2(STRB_W);
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TGT_W  = (NO_TGTS > 1) ? $clog2(NO_TGTS) : 1;

  // Action codes share the state encoding so a pending action maps straight to a state.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESUME = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_STOP   = 3'd3,
    ST_RESET  = 3'd4
  } state_e;

  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;

  logic [NO_TGTS-1:0]    rst_q, rst_d;
  logic [NO_TGTS-1:0]    req_q, req_d;
  logic [NO_TGTS-1:0]    paused_q, paused_d;
  logic [NO_TGTS-1:0]    stopped_q, stopped_d;
  logic [NO_TGTS-1:0]    timeout_q, timeout_d;

  state_e                state_q [NO_TGTS];
  state_e                state_d [NO_TGTS];
  logic [3:0]            pend_q  [NO_TGTS];
  logic [3:0]            pend_d  [NO_TGTS];
  logic [CNT_W-1:0]      cnt_q   [NO_TGTS];
  logic [CNT_W-1:0]      cnt_d   [NO_TGTS];
  logic [ADDR_WIDTH-1:0] bar_q   [NO_TGTS];
  logic [ADDR_WIDTH-1:0] bar_d   [NO_TGTS];
  logic [DATA_WIDTH-1:0] ier_q   [NO_TGTS];
  logic [DATA_WIDTH-1:0] ier_d   [NO_TGTS];

  logic [NO_TGTS-1:0]    busy_c;
  logic [ADDR_WIDTH-1:0] word_idx_c;
  logic                  idx_tgt_c;
  logic                  idx_bcr_c;
  logic [TGT_W-1:0]      sel_tgt_c;
  logic [1:0]            sel_reg_c;
  logic [3:0]            wr_code_c;
  logic                  code_bad_c;
  logic [NO_TGTS-1:0]    bcr_sel_c;

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Address decode and write-payload fields.
  always_comb begin : decode
    word_idx_c = paddr >> ALIGN;
    idx_tgt_c  = word_idx_c < ADDR_WIDTH'(4 * NO_TGTS);
    idx_bcr_c  = word_idx_c == ADDR_WIDTH'(4 * NO_TGTS);
    sel_tgt_c  = word_idx_c[TGT_W+1:2];
    sel_reg_c  = word_idx_c[1:0];
    wr_code_c  = pwdata[3:0];
    code_bad_c = wr_code_c > 4'd4;
    bcr_sel_c  = pwdata[16 +: NO_TGTS];
  end

  always_comb begin : busy_calc
    for (int t = 0; t < NO_TGTS; t++) begin
      busy_c[t] = (state_q[t] != ST_IDLE) || (pend_q[t] != 4'd0);
    end
  end

  always_comb begin : next_state
    pready_d  = pready_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    rst_d     = rst_q;
    req_d     = req_q;
    paused_d  = paused_q;
    stopped_d = stopped_q;
    timeout_d = timeout_q;
    for (int t = 0; t < NO_TGTS; t++) begin
      state_d[t] = state_q[t];
      pend_d[t]  = pend_q[t];
      cnt_d[t]   = cnt_q[t];
      bar_d[t]   = bar_q[t];
      ier_d[t]   = ier_q[t];
    end

    // Per-target control sequencing.
    for (int t = 0; t < NO_TGTS; t++) begin
      case (state_q[t])
        ST_IDLE: begin
          if (pend_q[t] != 4'd0) begin
            state_d[t] = state_e'(pend_q[t][2:0]);
            pend_d[t]  = 4'd0;
            cnt_d[t]   = '0;
          end
        end
        ST_RESUME: begin
          rst_d[t] = 1'b0;
          req_d[t] = 1'b0;
          if (!tgt_pause_ack[t]) begin
            paused_d[t]  = 1'b0;
            stopped_d[t] = 1'b0;
            state_d[t]   = ST_IDLE;
          end
        end
        ST_PAUSE, ST_STOP, ST_RESET: begin
          req_d[t] = 1'b1;
          if (tgt_pause_ack[t]) begin
            paused_d[t] = 1'b1;
            cnt_d[t]    = '0;
            if (state_q[t] != ST_PAUSE) begin
              rst_d[t]     = 1'b1;
              stopped_d[t] = 1'b1;
            end
            state_d[t] = (state_q[t] == ST_RESET) ? ST_RESUME : ST_IDLE;
          end else if (TIMEOUT != 0) begin
            if (cnt_q[t] == CNT_W'(TIMEOUT - 1)) begin
              timeout_d[t] = 1'b1;
              cnt_d[t]     = '0;
              state_d[t]   = ST_IDLE;
            end else begin
              cnt_d[t] = cnt_q[t] + CNT_W'(1);
            end
          end
        end
        default: state_d[t] = ST_IDLE;
      endcase
    end

    // APB: the response is computed when the setup phase is sampled.
    if (psel && penable && pready_q) begin
      pready_d  = 1'b0;
      prdata_d  = '0;
      pslverr_d = 1'b0;
    end else if (psel && !pready_q) begin
      pready_d  = 1'b1;
      prdata_d  = '0;
      pslverr_d = 1'b0;
      if (idx_bcr_c) begin
        if (pwrite) begin
          if (code_bad_c || ((bcr_sel_c & busy_c) != '0)) begin
            pslverr_d = 1'b1;
          end else begin
            for (int t = 0; t < NO_TGTS; t++) begin
              if (bcr_sel_c[t]) begin
                pend_d[t]    = wr_code_c;
                timeout_d[t] = 1'b0;
              end
            end
          end
        end else begin
          prdata_d = DATA_WIDTH'(busy_c);
        end
      end else if (idx_tgt_c) begin
        case (sel_reg_c)
          2'd0: begin
            if (pwrite) pslverr_d = 1'b1;
            else prdata_d = DATA_WIDTH'({timeout_q[sel_tgt_c], busy_c[sel_tgt_c],
                                         stopped_q[sel_tgt_c], paused_q[sel_tgt_c]});
          end
          2'd1: begin
            if (pwrite) begin
              if (pstrb[0]) begin
                if (code_bad_c || busy_c[sel_tgt_c]) begin
                  pslverr_d = 1'b1;
                end else begin
                  pend_d[sel_tgt_c]    = wr_code_c;
                  timeout_d[sel_tgt_c] = 1'b0;
                end
              end
            end else begin
              prdata_d = DATA_WIDTH'(pend_q[sel_tgt_c]);
            end
          end
          2'd2: begin
            if (pwrite) begin
              if (busy_c[sel_tgt_c]) pslverr_d = 1'b1;
              else bar_d[sel_tgt_c] = ADDR_WIDTH'(byte_merge(DATA_WIDTH'(bar_q[sel_tgt_c]),
                                                             pwdata, pstrb));
            end else begin
              prdata_d = DATA_WIDTH'(bar_q[sel_tgt_c]);
            end
          end
          default: begin
            if (pwrite) ier_d[sel_tgt_c] = byte_merge(ier_q[sel_tgt_c], pwdata, pstrb);
            else prdata_d = ier_q[sel_tgt_c];
          end
        endcase
      end else begin
        pslverr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      rst_q     <= '1;
      req_q     <= '1;
      paused_q  <= '1;
      stopped_q <= '1;
      timeout_q <= '0;
      for (int t = 0; t < NO_TGTS; t++) begin
        state_q[t] <= EN_BOOTSTRAP[t] ? ST_RESUME : ST_IDLE;
        pend_q[t]  <= 4'd0;
        cnt_q[t]   <= '0;
        bar_q[t]   <= RST_BOOT_ADDR;
        ier_q[t]   <= '0;
      end
    end else begin
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      rst_q     <= rst_d;
      req_q     <= req_d;
      paused_q  <= paused_d;
      stopped_q <= stopped_d;
      timeout_q <= timeout_d;
      for (int t = 0; t < NO_TGTS; t++) begin
        state_q[t] <= state_d[t];
        pend_q[t]  <= pend_d[t];
        cnt_q[t]   <= cnt_d[t];
        bar_q[t]   <= bar_d[t];
        ier_q[t]   <= ier_d[t];
      end
    end
  end

  // Interrupt gating is combinational so irq_vec reaches tgt_irq in the same cycle.
  always_comb begin : outputs
    for (int t = 0; t < NO_TGTS; t++) begin
      tgt_irq[t]                          = |(ier_q[t] & irq_vec[t*DATA_WIDTH +: DATA_WIDTH]);
      tgt_boot_addr[t*ADDR_WIDTH +: ADDR_WIDTH] = bar_q[t];
    end
  end

  assign pready        = pready_q;
  assign prdata        = prdata_q;
  assign pslverr       = pslverr_q;
  assign tgt_rst       = rst_q;
  assign tgt_pause_req = req_q;

endmodule

// File: tb/tb_adam_periph_syscfg_multi.sv
// Randomized bench for adam_periph_syscfg_multi against an outcome-level model
// of targets that acknowledge pause requests after a programmable delay.
module tb_adam_periph_syscfg_multi;

  localparam int unsigned NT  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned TO  = 16;
  localparam logic [NT-1:0] BOOT = 4'b0001;
  localparam logic [AW-1:0] RBA  = 32'h1000_0000;

  logic              clk, rst_n;
  logic [AW-1:0]     paddr;
  logic              psel, penable, pwrite;
  logic [DW-1:0]     pwdata;
  logic [DW/8-1:0]   pstrb;
  logic              pready, pslverr;
  logic [DW-1:0]     prdata;
  logic [NT*DW-1:0]  irq_vec;
  logic [NT-1:0]     tgt_rst, tgt_pause_req, tgt_pause_ack, tgt_irq;
  logic [NT*AW-1:0]  tgt_boot_addr;

  adam_periph_syscfg_multi #(
    .NO_TGTS(NT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .EN_BOOTSTRAP(BOOT), .RST_BOOT_ADDR(RBA), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .irq_vec(irq_vec), .tgt_rst(tgt_rst),
    .tgt_pause_req(tgt_pause_req), .tgt_pause_ack(tgt_pause_ack),
    .tgt_boot_addr(tgt_boot_addr), .tgt_irq(tgt_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Target model: ack is the pause request delayed by dly cycles, or forced low.
  logic [7:0]    hist [NT];
  int            dly  [NT];
  logic [NT-1:0] stuck;
  always @(negedge clk) begin
    for (int t = 0; t < NT; t++) begin
      if (!rst_n) hist[t] = 8'h00;
      else hist[t] = {hist[t][6:0], tgt_pause_req[t]};
      tgt_pause_ack[t] = !stuck[t] && hist[t][dly[t]-1];
    end
  end

  // Expected architectural state per target.
  logic [NT-1:0] m_paused, m_stopped, m_timeout, m_rst, m_req;
  logic [31:0]   m_bar [NT];
  logic [31:0]   m_ier [NT];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] a_reg(input int t, input int r);
    return 32'((4 * t + r) * 4);
  endfunction

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sr_exp(input int t);
    return {28'd0, m_timeout[t], 1'b0, m_stopped[t], m_paused[t]};
  endfunction

  task automatic apb(input logic w, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, output logic [31:0] rd, output logic err,
                     output int lat);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = addr; pwdata = data; pstrb = strb;
    @(negedge clk);
    penable = 1'b1;
    lat = 0;
    while (!pready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!pready) check("pready_timeout", 64'(pready), 64'd1);
    rd  = prdata;
    err = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    output logic err);
    logic [31:0] rd;
    int lat;
    apb(1'b1, addr, data, strb, rd, err, lat);
  endtask

  task automatic rd_reg(input logic [31:0] addr, output logic [31:0] rd, output logic err);
    int lat;
    apb(1'b0, addr, 32'd0, 4'h0, rd, err, lat);
  endtask

  task automatic wait_idle(input logic [NT-1:0] mask, output int unsigned t_end);
    logic [31:0] rd;
    logic e;
    int n;
    n = 0;
    rd_reg(a_reg(NT, 0), rd, e);
    while (((rd[NT-1:0] & mask) != '0) && n < 100) begin
      rd_reg(a_reg(NT, 0), rd, e);
      n++;
    end
    t_end = cyc;
    check("idle_wait", 64'(rd[NT-1:0] & mask), 64'd0);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] rd;
    logic e;
    for (int t = 0; t < NT; t++) begin
      rd_reg(a_reg(t, 0), rd, e);
      check({tag, "_sr"}, 64'(rd), 64'(sr_exp(t)));
    end
    check({tag, "_tgt_rst"}, 64'(tgt_rst), 64'(m_rst));
    check({tag, "_pause_req"}, 64'(tgt_pause_req), 64'(m_req));
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_bar[t] = RBA;
      m_ier[t] = 32'd0;
    end
    m_timeout = '0;
    m_paused  = ~BOOT;
    m_stopped = ~BOOT;
    m_rst     = ~BOOT;
    m_req     = ~BOOT;
  endtask

  // Outcome of an accepted action once the target has gone idle again.
  task automatic apply_action(input int t, input int unsigned code, input logic st);
    m_timeout[t] = 1'b0;
    case (code)
      1: begin m_paused[t] = 1'b0; m_stopped[t] = 1'b0; m_rst[t] = 1'b0; m_req[t] = 1'b0; end
      2, 3, 4: begin
        if (st) begin
          m_timeout[t] = 1'b1;
          m_req[t]     = 1'b1;
        end else if (code == 2) begin
          m_paused[t] = 1'b1; m_req[t] = 1'b1;
        end else if (code == 3) begin
          m_paused[t] = 1'b1; m_stopped[t] = 1'b1; m_rst[t] = 1'b1; m_req[t] = 1'b1;
        end else begin
          m_paused[t] = 1'b0; m_stopped[t] = 1'b0; m_rst[t] = 1'b0; m_req[t] = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic drive_irq_and_check();
    logic [NT-1:0] exp;
    for (int t = 0; t < NT; t++)
      irq_vec[t*DW +: DW] = $urandom & $urandom & $urandom & $urandom;
    #1;
    for (int t = 0; t < NT; t++) exp[t] = |(m_ier[t] & irq_vec[t*DW +: DW]);
    check("tgt_irq", 64'(tgt_irq), 64'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, d;
    logic [3:0] s;
    logic e, st;
    int lat, t;
    int unsigned code, sel, t0, t1;

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; irq_vec = '0; stuck = '0;
    for (int i = 0; i < NT; i++) dly[i] = 2;

    repeat (3) @(negedge clk);
    check("rst_pready", 64'(pready), 64'd0);
    check("rst_tgt_rst", 64'(tgt_rst), 64'hF);
    check("rst_pause_req", 64'(tgt_pause_req), 64'hF);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    model_reset();
    check_all("boot");
    for (int i = 0; i < NT; i++) begin
      rd_reg(a_reg(i, 2), rd, e);
      check("boot_bar", 64'(rd), 64'(RBA));
      rd_reg(a_reg(i, 3), rd, e);
      check("boot_ier", 64'(rd), 64'd0);
    end

    // Pause a running target with a slow acknowledge.
    dly[0] = 5;
    apb(1'b1, a_reg(0, 1), 32'd2, 4'hF, rd, e, lat);
    check("pause_err", 64'(e), 64'd0);
    check("pready_latency", 64'(lat), 64'd0);
    rd_reg(a_reg(0, 0), rd, e);
    check("pause_busy", 64'(rd[2]), 64'd1);
    wait_idle(4'b0001, t1);
    apply_action(0, 2, 1'b0);
    check_all("pause");

    // Interrupt gating and illegal accesses.
    wr(a_reg(0, 3), 32'h1, 4'hF, e);
    m_ier[0] = 32'h1;
    @(negedge clk);
    irq_vec[0] = 1'b1; #1;
    check("irq_on", 64'(tgt_irq[0]), 64'd1);
    irq_vec[0] = 1'b0; #1;
    check("irq_off", 64'(tgt_irq[0]), 64'd0);
    wr(a_reg(0, 1), 32'd7, 4'hF, e);
    check("mr_code7_err", 64'(e), 64'd1);
    rd_reg(a_reg(NT, 1), rd, e);
    check("bad_index_err", 64'(e), 64'd1);

    for (int it = 0; it < 80; it++) begin
      t = int'($urandom_range(0, NT - 1));
      case ($urandom_range(0, 5))
        0: begin
          d = $urandom; s = 4'($urandom_range(0, 15));
          wr(a_reg(t, 3), d, s, e);
          check("ier_err", 64'(e), 64'd0);
          m_ier[t] = merge32(m_ier[t], d, s);
          rd_reg(a_reg(t, 3), rd, e);
          check("ier_rd", 64'(rd), 64'(m_ier[t]));
          drive_irq_and_check();
        end
        1: begin
          d = $urandom; s = 4'($urandom_range(0, 15));
          wr(a_reg(t, 2), d, s, e);
          check("bar_err", 64'(e), 64'd0);
          m_bar[t] = merge32(m_bar[t], d, s);
          rd_reg(a_reg(t, 2), rd, e);
          check("bar_rd", 64'(rd), 64'(m_bar[t]));
          check("boot_addr", 64'(tgt_boot_addr[t*AW +: AW]), 64'(m_bar[t]));
        end
        2: begin
          code = $urandom_range(0, 6);
          st = (code >= 2) && (code <= 4) && ($urandom_range(0, 3) == 0);
          dly[t] = int'($urandom_range(1, 5));
          stuck[t] = st;
          wr(a_reg(t, 1), 32'(code), 4'hF, e);
          check("mr_err", 64'(e), 64'(code > 4));
          if (code <= 4) begin
            wait_idle(NT'(1 << t), t1);
            apply_action(t, code, st);
          end
          stuck[t] = 1'b0;
          check_all("mr");
        end
        3: begin
          sel = $urandom_range(0, 15);
          code = $urandom_range(0, 5);
          for (int i = 0; i < NT; i++) dly[i] = int'($urandom_range(1, 5));
          wr(a_reg(NT, 0), (sel << 16) | code, 4'hF, e);
          check("bcr_err", 64'(e), 64'(code > 4));
          if (code <= 4) begin
            wait_idle(NT'(sel), t1);
            for (int i = 0; i < NT; i++) if (sel[i]) apply_action(i, code, 1'b0);
          end
          check_all("bcr");
        end
        4: begin
          stuck[t] = 1'b1;
          wr(a_reg(t, 1), 32'd2, 4'hF, e);
          t0 = cyc;
          check("to_mr_err", 64'(e), 64'd0);
          wr(a_reg(t, 2), 32'h8000_0000, 4'hF, e);
          check("busy_bar_err", 64'(e), 64'd1);
          wr(a_reg(t, 1), 32'd1, 4'hF, e);
          check("busy_mr_err", 64'(e), 64'd1);
          wr(a_reg(NT, 0), 32'h000F_0004, 4'hF, e);
          check("busy_bcr_err", 64'(e), 64'd1);
          wait_idle(NT'(1 << t), t1);
          check("to_window", 64'((t1 - t0) >= 12 && (t1 - t0) <= 24), 64'd1);
          apply_action(t, 2, 1'b1);
          stuck[t] = 1'b0;
          rd_reg(a_reg(t, 2), rd, e);
          check("busy_bar_kept", 64'(rd), 64'(m_bar[t]));
          check_all("to");
        end
        default: begin
          code = $urandom_range(4 * NT + 1, 4 * NT + 10);
          if ($urandom_range(0, 1) == 1) wr(32'(code * 4), $urandom, 4'hF, e);
          else rd_reg(32'(code * 4), rd, e);
          check("bad_addr_err", 64'(e), 64'd1);
          wr(a_reg(t, 0), $urandom, 4'hF, e);
          check("sr_wr_err", 64'(e), 64'd1);
          rd_reg(a_reg(t, 0), rd, e);
          check("sr_kept", 64'(rd), 64'(sr_exp(t)));
        end
      endcase
    end

    // Reset arriving in the middle of a transfer.
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a_reg(1, 3);
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_pready", 64'(pready), 64'd0);
    check("midrst_pslverr", 64'(pslverr), 64'd0);
    check("midrst_tgt_rst", 64'(tgt_rst), 64'hF);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NT; i++) dly[i] = 2;
    repeat (10) @(negedge clk);
    model_reset();
    rd_reg(a_reg(1, 3), rd, e);
    check("midrst_ier", 64'(rd), 64'd0);
    check_all("midrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adam_periph_syscfg_multi.md
ADAM_PERIPH_SYSCFG_MULTI -- requirements
Module: adam_periph_syscfg_multi

Interface
REQ-001 SHALL have parameter NO_TGTS, default 4, number of controlled targets (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width; ADDR_WIDTH, default 32, APB address width.
REQ-003 SHALL have parameter EN_BOOTSTRAP, default '0, NO_TGTS-bit mask of targets auto-resumed after reset.
REQ-004 SHALL have parameter RST_BOOT_ADDR, default 0, reset value of every BAR.
REQ-005 SHALL have parameter TIMEOUT, default 1024, max cycles waiting for a pause ack (0 = disabled).
REQ-006 SHALL have ports: clk in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-007 SHALL have APB slave ports: paddr in ADDR_WIDTH; psel, penable, pwrite in 1; pwdata in DATA_WIDTH; pstrb in DATA_WIDTH/8; pready out 1; prdata out DATA_WIDTH; pslverr out 1.
REQ-008 SHALL have target ports: irq_vec in NO_TGTS*DATA_WIDTH; tgt_rst out NO_TGTS; tgt_pause_req out NO_TGTS; tgt_pause_ack in NO_TGTS; tgt_boot_addr out NO_TGTS*ADDR_WIDTH; tgt_irq out NO_TGTS.

Function
REQ-009 SHALL decode word index = paddr >> log2(DATA_WIDTH/8); index 4t+{0,1,2,3} = SR, MR, BAR, IER of target t; index 4*NO_TGTS = BCR (broadcast); all other indices -> pslverr.
REQ-010 SHALL register pready: rise the cycle after psel sampled high with pready low; fall, with prdata and pslverr cleared to 0, the cycle after psel&&penable&&pready sampled.
REQ-011 SR SHALL read {..0, timeout, busy, stopped, paused} in bits [3:0]; writes -> pslverr, no state change.
REQ-012 MR SHALL read the pending action in [3:0]; write SHALL load pwdata[3:0] masked by pstrb[0] when target state IDLE and no action pending, else pslverr.
REQ-013 Action codes: 0 IDLE, 1 RESUME, 2 PAUSE, 3 STOP, 4 RESET; MR/BCR write of codes 5..15 SHALL return pslverr, no change.
REQ-014 BAR write SHALL apply byte-masked merge only when target IDLE with no pending action, else pslverr; reads always allowed.
REQ-015 IER SHALL be byte-masked read/write at any time; tgt_irq[t] SHALL be combinational OR-reduce of ier[t] & irq_vec slice t.
REQ-016 BCR write SHALL apply pwdata[3:0] to every target t with pwdata[16+t]=1; if any selected target busy or pending, SHALL reject all with pslverr; BCR read SHALL return busy mask in [NO_TGTS-1:0].
REQ-017 Per-target FSM states IDLE, RESUME, PAUSE, STOP, RESET; in IDLE with pending action SHALL move to that state next cycle and clear pending.
REQ-018 RESUME SHALL drive tgt_rst=0, tgt_pause_req=0; when ack low SHALL clear paused, stopped and return IDLE.
REQ-019 PAUSE SHALL drive tgt_pause_req=1; when ack high SHALL set paused, return IDLE.
REQ-020 STOP SHALL as PAUSE, then on ack also assert tgt_rst, set stopped, return IDLE; RESET SHALL as STOP but go to RESUME.
REQ-021 Per-target counter SHALL count cycles in PAUSE/STOP/RESET awaiting ack; on reaching TIMEOUT SHALL set timeout flag, keep tgt_pause_req=1, return IDLE without changing paused/stopped/tgt_rst.
REQ-022 timeout flag SHALL clear on next accepted MR/BCR write to that target; busy = state!=IDLE or pending.
REQ-023 A write to target t SHALL never affect other targets' state, counters or registers.
REQ-024 tgt_boot_addr slice t SHALL equal BAR t continuously.

Reset
REQ-025 On rst_n low, asynchronously: pready, pslverr, prdata = 0; pending = IDLE; BAR = RST_BOOT_ADDR; IER = 0; tgt_rst = all 1; tgt_pause_req = all 1; paused = stopped = 1; timeout = 0; counters = 0.
REQ-026 After reset, FSM t SHALL start in RESUME if EN_BOOTSTRAP[t], else IDLE; reset mid-transfer SHALL abort it with no register update.

Verification
REQ-027 Reset, EN_BOOTSTRAP=4'b0001, ack follows req after 2 cycles -> target 0 tgt_rst=0, SR0=0x0; targets 1-3 SR=0x3, tgt_rst=1.
REQ-028 Write MR1=2 (PAUSE) with target 1 running, ack after 5 cycles -> SR1 busy until ack, then SR1=0x1, pready one cycle after setup, pslverr=0.
REQ-029 Write BAR2=0x8000_0000 while target 2 busy -> pslverr=1, BAR2 unchanged; again when IDLE with pstrb=4'b1000 -> BAR2 only byte 3 updated.
REQ-030 TIMEOUT=16, MR3=3 (STOP), ack held low -> after 16 cycles SR3 timeout=1, tgt_rst[3] unchanged, state IDLE; next MR3 write clears timeout.
REQ-031 BCR write 0x000F_0004 (RESET all) with target 2 busy -> pslverr, no target changes; when all IDLE -> all targets cycle rst and resume.
REQ-032 IER0=0x1, irq_vec bit0 of target 0 toggled -> tgt_irq[0] follows same cycle; write MR0=7 -> pslverr, paddr index 4*NO_TGTS+1 -> pslverr.
